fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register of the RV32I pipeline; directly upstream of decode/control.
- Maintains the PC, fetches from instruction memory over a req/gnt/rvalid handshake, and presents {pc, instr} to decode; ifid_instr[6:0] is the control opcode.
- Honours stall from the hazard unit and redirect (branch/jump taken) from EX, inserting NOP bubbles where needed.

---
 rtl/rv32i_pkg.sv | 22 ++
 rtl/fetch_stage_ifid_reg.sv | 89 ++++++++
 rtl/fetch_stage.sv | 157 +++++++++++++++
 tb/tb_fetch_stage.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: bubble encoding, base opcodes and the fetch FSM states.
package rv32i_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_KILL,
        S_HOLD
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// Pipeline register with flush > stall-hold > load > bubble priority (IF/ID, reused for ID/EX).
// FETCH_FAULT_EN adds a fault bit that travels with the instruction.
module ifid_reg #(
    parameter int unsigned XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            stall_i,
    input  logic            load_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     instr_i,
`ifdef FETCH_FAULT_EN
    input  logic            fault_i,
    output logic            fault_o,
`endif
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic [31:0]     instr_o
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
`ifdef FETCH_FAULT_EN
    logic            fault_q, fault_d;
`endif

    // A stall only freezes a real instruction; an empty register keeps accepting new work.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
`ifdef FETCH_FAULT_EN
        fault_d = fault_q;
`endif
        if (flush_i) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
`ifdef FETCH_FAULT_EN
            fault_d = 1'b0;
`endif
        end else if (!(stall_i && valid_q)) begin
            if (load_i) begin
                valid_d = 1'b1;
                pc_d    = pc_i;
                instr_d = instr_i;
`ifdef FETCH_FAULT_EN
                fault_d = fault_i;
`endif
            end else begin
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
`ifdef FETCH_FAULT_EN
                fault_d = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
`ifdef FETCH_FAULT_EN
            fault_q <= 1'b0;
`endif
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
`ifdef FETCH_FAULT_EN
            fault_q <= fault_d;
`endif
        end
    end

    assign valid_o    = valid_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_q + XLEN'(4);
    assign instr_o    = instr_q;
`ifdef FETCH_FAULT_EN
    assign fault_o    = fault_q;
`endif

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: PC, single-outstanding req/gnt/rvalid fetch, skid buffer and IF/ID register.
// Define FETCH_FAULT_EN to add imem_rerr / ifid_fault bus-error reporting.
module fetch_stage #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
`ifdef FETCH_FAULT_EN
    input  logic            imem_rerr,
    output logic            ifid_fault,
`endif
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            ifid_valid,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_pc_plus4,
    output logic [31:0]     ifid_instr
);
    import rv32i_pkg::*;

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [31:0]     skid_instr_q, skid_instr_d;
    logic [XLEN-1:0] redirect_tgt;
    logic [31:0]     rx_instr;
    logic            load;
    logic [31:0]     load_instr;
`ifdef FETCH_FAULT_EN
    logic            skid_fault_q, skid_fault_d;
    logic            load_fault;
    assign rx_instr = imem_rerr ? NOP_INSTR : imem_rdata;
`else
    assign rx_instr = imem_rdata;
`endif

    assign redirect_tgt = redirect_pc & ALIGN_MASK;
    assign imem_addr    = pc_q & ALIGN_MASK;

    // Fetch FSM: the request is withheld during reset and on any redirect cycle.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_pc_d   = fetch_pc_q;
        skid_instr_d = skid_instr_q;
        imem_req     = 1'b0;
        load         = 1'b0;
        load_instr   = rx_instr;
`ifdef FETCH_FAULT_EN
        skid_fault_d = skid_fault_q;
        load_fault   = imem_rerr;
`endif
        case (state_q)
            S_REQ: begin
                imem_req = !redirect && rst_n;
                if (redirect) begin
                    pc_d = redirect_tgt;
                end else if (imem_gnt) begin
                    fetch_pc_d = pc_q & ALIGN_MASK;
                    pc_d       = pc_q + XLEN'(4);
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_d    = redirect_tgt;
                    state_d = imem_rvalid ? S_REQ : S_KILL;
                end else if (imem_rvalid) begin
                    if (stall && ifid_valid) begin
                        skid_instr_d = rx_instr;
`ifdef FETCH_FAULT_EN
                        skid_fault_d = imem_rerr;
`endif
                        state_d = S_HOLD;
                    end else begin
                        load    = 1'b1;
                        state_d = S_REQ;
                    end
                end
            end
            S_KILL: begin
                if (redirect) begin
                    pc_d = redirect_tgt;
                end
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            S_HOLD: begin
                load_instr = skid_instr_q;
`ifdef FETCH_FAULT_EN
                load_fault = skid_fault_q;
`endif
                if (redirect) begin
                    pc_d    = redirect_tgt;
                    state_d = S_REQ;
                end else if (!stall) begin
                    load    = 1'b1;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            fetch_pc_q   <= '0;
            skid_instr_q <= NOP_INSTR;
`ifdef FETCH_FAULT_EN
            skid_fault_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_pc_q   <= fetch_pc_d;
            skid_instr_q <= skid_instr_d;
`ifdef FETCH_FAULT_EN
            skid_fault_q <= skid_fault_d;
`endif
        end
    end

    ifid_reg #(
        .XLEN      (XLEN),
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (redirect),
        .stall_i    (stall),
        .load_i     (load),
        .pc_i       (fetch_pc_q),
        .instr_i    (load_instr),
`ifdef FETCH_FAULT_EN
        .fault_i    (load_fault),
        .fault_o    (ifid_fault),
`endif
        .valid_o    (ifid_valid),
        .pc_o       (ifid_pc),
        .pc_plus4_o (ifid_pc_plus4),
        .instr_o    (ifid_instr)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios, a redirect vector table and a
// randomized run judged by program-order rules on the fetched and consumed instruction streams.
module tb_fetch_stage;
    import rv32i_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        stall, redirect;
    logic [31:0] redirect_pc;
    logic        ifid_valid;
    logic [31:0] ifid_pc, ifid_pc_plus4, ifid_instr;
`ifdef FETCH_FAULT_EN
    logic        imem_rerr = 1'b0;
    logic        ifid_fault;
`endif

    fetch_stage #(
        .XLEN      (32),
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
`ifdef FETCH_FAULT_EN
        .imem_rerr     (imem_rerr),
        .ifid_fault    (ifid_fault),
`endif
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .ifid_valid    (ifid_valid),
        .ifid_pc       (ifid_pc),
        .ifid_pc_plus4 (ifid_pc_plus4),
        .ifid_instr    (ifid_instr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    // Memory model knobs and state: one outstanding request, response >= 1 cycle after grant.
    int          gntPct = 100;
    int          latExtra = 0;
    bit          respEnable = 1'b1;
    logic [31:0] memConst = 32'h0;
    bit          memBusy = 1'b0;
    logic [31:0] memAddr = 32'h0;
    int          memCnt = 0;
    bit          lastGnt = 1'b0;
    logic [31:0] lastGntAddr = 32'h0;

    // Reference expectations: next fetch address and next PC decode should consume.
    logic [31:0] expFetch = RESET_PC;
    logic [31:0] expCons = RESET_PC;
    int          consumed = 0;

    typedef struct {
        logic [31:0] rpc;
        bit          withRvalid;
        logic [31:0] expAddr;
        logic [31:0] expNext;
    } redirVec_t;

    redirVec_t vecs[5];

    function automatic logic [31:0] memFn(input logic [31:0] a);
        if (memConst != 32'h0) return memConst;
        return ((a ^ 32'h5A5A_0000) * 32'h0001_0003) | 32'h0000_0003;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        #1;
        checkOutput("rst_req", imem_req, 1'b0);
        checkOutput("rst_valid", ifid_valid, 1'b0);
        checkOutput("rst_instr", ifid_instr, NOP_INSTR);
        checkOutput("rst_pc", ifid_pc, 32'h0);
        checkOutput("rst_pc_plus4", ifid_pc_plus4, 32'h4);
        memBusy = 1'b0;
        expFetch = RESET_PC;
        expCons = RESET_PC;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock of stimulus; the memory model reacts to imem_req and every cycle is judged by the rules.
    task automatic applyStimulus(input logic st, input logic rd, input logic [31:0] rpc);
        logic        preValid;
        logic [31:0] prePc, preInstr, prePlus4;
        @(negedge clk);
        stall = st;
        redirect = rd;
        redirect_pc = rpc;
        if (memBusy && memCnt == 0 && respEnable) begin
            imem_rvalid = 1'b1;
            imem_rdata = memFn(memAddr);
            memBusy = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata = $urandom;
            if (memBusy && memCnt > 0) memCnt--;
        end
        #1;
        if (rd) checkOutput("req_during_redirect", imem_req, 1'b0);
        if (memBusy) checkOutput("single_outstanding", imem_req, 1'b0);
        imem_gnt = imem_req && (int'($urandom_range(0, 99)) < gntPct);
        lastGnt = imem_gnt;
        if (imem_gnt) begin
            checkOutput("fetch_addr", imem_addr, expFetch);
            lastGntAddr = imem_addr;
            expFetch = imem_addr + 32'd4;
            memBusy = 1'b1;
            memAddr = imem_addr;
            memCnt = int'($urandom_range(0, latExtra));
        end
        if (rd) expFetch = rpc & ~32'h3;
        preValid = ifid_valid;
        prePc = ifid_pc;
        preInstr = ifid_instr;
        prePlus4 = ifid_pc_plus4;
        if (preValid && !st && !rd) begin
            checkOutput("consume_order", prePc, expCons);
            expCons = prePc + 32'd4;
            consumed++;
        end
        if (rd) expCons = rpc & ~32'h3;
        @(posedge clk);
        #1;
        if (rd) begin
            checkOutput("flush_valid", ifid_valid, 1'b0);
            checkOutput("flush_instr", ifid_instr, NOP_INSTR);
        end else if (st && preValid) begin
            checkOutput("hold_valid", ifid_valid, 1'b1);
            checkOutput("hold_pc", ifid_pc, prePc);
            checkOutput("hold_instr", ifid_instr, preInstr);
            checkOutput("hold_pc_plus4", ifid_pc_plus4, prePlus4);
        end
        if (ifid_valid) begin
            checkOutput("instr_matches_pc", ifid_instr, memFn(ifid_pc));
            checkOutput("pc_plus4", ifid_pc_plus4, ifid_pc + 32'd4);
        end else begin
            checkOutput("bubble_is_nop", ifid_instr, NOP_INSTR);
        end
`ifdef FETCH_FAULT_EN
        checkOutput("no_fault", ifid_fault, 1'b0);
`endif
    endtask

    task automatic waitGnt(input string name, input int maxCycles);
        int n = 0;
        lastGnt = 1'b0;
        while (!lastGnt && n < maxCycles) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            n++;
        end
        if (!lastGnt) checkOutput({name, "_timeout"}, 32'h0, 32'h1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{32'h0000_0103, 1'b0, 32'h0000_0100, 32'h0000_0104};
        vecs[1] = '{32'h0000_0103, 1'b1, 32'h0000_0100, 32'h0000_0104};
        vecs[2] = '{32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[3] = '{32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[4] = '{32'h0000_2001, 1'b1, 32'h0000_2000, 32'h0000_2004};

        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;

        // Zero-wait memory after reset: fetches at 0, 4, 8 with 2-cycle spacing.
        memConst = 32'h0050_0093;
        doReset();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("t1_gnt0", lastGnt, 1'b1);
        checkOutput("t1_addr0", lastGntAddr, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("t1_instr", ifid_instr, 32'h0050_0093);
        checkOutput("t1_pc", ifid_pc, 32'h0);
        checkOutput("t1_pc_plus4", ifid_pc_plus4, 32'h4);
        checkOutput("t1_valid", ifid_valid, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("t1_addr4", lastGntAddr, 32'h4);
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("t1_addr8", lastGntAddr, 32'h8);
        memConst = 32'h0;

        // Response under stall goes to the skid buffer, then drains when stall drops.
        doReset();
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("t2_valid0", ifid_valid, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0);
            checkOutput("t2_hold_pc", ifid_pc, 32'h0);
        end
        checkOutput("t2_no_gnt_in_hold", lastGnt, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("t2_skid_pc", ifid_pc, 32'h4);
        checkOutput("t2_skid_valid", ifid_valid, 1'b1);
        checkOutput("t2_skid_instr", ifid_instr, memFn(32'h4));
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("t2_next_gnt", lastGnt, 1'b1);
        checkOutput("t2_next_addr", lastGntAddr, 32'h8);

        // Redirect while waiting on memory, with and without a same-cycle response.
        for (int v = 0; v < 5; v++) begin
            doReset();
            respEnable = 1'b0;
            applyStimulus(1'b0, 1'b0, 32'h0);
            respEnable = vecs[v].withRvalid;
            applyStimulus(1'b0, 1'b1, vecs[v].rpc);
            checkOutput("tbl_flush_valid", ifid_valid, 1'b0);
            checkOutput("tbl_flush_instr", ifid_instr, NOP_INSTR);
            if (!vecs[v].withRvalid) begin
                respEnable = 1'b1;
                applyStimulus(1'b0, 1'b0, 32'h0);
                checkOutput("tbl_stale_ignored", ifid_valid, 1'b0);
            end
            respEnable = 1'b1;
            waitGnt("tbl_gnt", 5);
            checkOutput("tbl_target_addr", lastGntAddr, vecs[v].expAddr);
            applyStimulus(1'b0, 1'b0, 32'h0);
            checkOutput("tbl_target_pc", ifid_pc, vecs[v].expAddr);
            checkOutput("tbl_target_valid", ifid_valid, 1'b1);
            waitGnt("tbl_gnt2", 5);
            checkOutput("tbl_next_addr", lastGntAddr, vecs[v].expNext);
        end

        // Redirect and stall together: flush wins and no request that cycle.
        doReset();
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h0000_0200);
        checkOutput("t4_valid", ifid_valid, 1'b0);
        checkOutput("t4_instr", ifid_instr, NOP_INSTR);
        checkOutput("t4_no_gnt", lastGnt, 1'b0);
        waitGnt("t4_gnt", 5);
        checkOutput("t4_addr", lastGntAddr, 32'h0000_0200);

        // Reset in the middle of a transaction; the stale response must be ignored.
        doReset();
        respEnable = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        doReset();
        @(negedge clk);
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0050_0093;
        @(posedge clk);
        #1;
        checkOutput("t5_stale_valid", ifid_valid, 1'b0);
        checkOutput("t5_stale_instr", ifid_instr, NOP_INSTR);
        respEnable = 1'b1;
        waitGnt("t5_gnt", 5);
        checkOutput("t5_first_addr", lastGntAddr, RESET_PC);

        // Randomized traffic: variable grant/latency, stalls and redirects.
        doReset();
        gntPct = 70;
        latExtra = 3;
        consumed = 0;
        for (int c = 0; c < 3000; c++) begin
            applyStimulus(($urandom % 100) < 30, ($urandom % 100) < 5, $urandom);
        end
        checkOutput("liveness", 32'(consumed > 100), 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
